syscall_print_arbiter: RTL and testbench
========================================

// Module: syscall_print_arbiter
// PURPOSE
//  Shares the single data-memory port between the CPU datapath and a print_string syscall engine.
//  On syscall code 4, stalls the CPU and walks the NUL-terminated string at $a0 one word at a time.
//  Emits one character per valid/ready handshake to the console sink.
//  Sits between the CPU load/store path and the data memory (combinational read, negedge write).
// PARAMETERS
//  MAX_CHARS    256  hard cap on characters emitted per syscall; 0 = unlimited
//  PRINT_CODE   4    $v0 value that selects print_string
// PORTS
//  clk             in   1   system clock, all state updates on posedge
//  rst_n           in   1   asynchronous active-low reset
//  cpu_mem_read    in   1   CPU load request
//  cpu_mem_write   in   1   CPU store request
//  cpu_address     in   32  CPU byte address
//  cpu_write_data  in   32  CPU store data
//  cpu_read_data   out  32  load data returned to CPU (= mem_read_data)
//  syscall_valid   in   1   decoded syscall instruction in execute
//  syscall_code    in   32  $v0
//  syscall_arg     in   32  $a0, string start byte address
//  cpu_stall       out  1   freeze PC/pipeline while high
//  mem_read        out  1   to data memory
//  mem_write       out  1   to data memory
//  mem_address     out  32  to data memory (byte address)
//  mem_write_data  out  32  to data memory
//  mem_read_data   in   32  from data memory, combinational
//  char_valid      out  1   character available
//  char_data       out  8   character byte
//  char_ready      in   1   sink accepts character
//  busy            out  1   engine owns the memory port (state != IDLE)
//  done            out  1   one-cycle pulse, string finished
//  truncated       out  1   sticky until next accept: last string hit MAX_CHARS
// BEHAVIOUR
//  Reset: state=IDLE; word_reg, addr_reg, count=0; truncated=0; all outputs 0 / pass-through.
//  States: IDLE, FETCH, EMIT, DONE.
//  IDLE: memory port = CPU signals. Accept when syscall_valid && syscall_code==PRINT_CODE:
//    cpu_stall=1 combinationally in the same cycle; mem_read/mem_write forced 0 in that cycle;
//    addr_reg<=syscall_arg; count<=0; truncated<=0; -> FETCH.
//    Other syscall codes are ignored: no stall, CPU keeps the port.
//  FETCH: mem_read=1, mem_address={addr_reg[31:2],2'b00}, mem_write=0.
//    word_reg<=mem_read_data; -> EMIT. One cycle, no wait states.
//  EMIT: byte = word_reg[8*addr_reg[1:0] +: 8] (little-endian).
//    byte==0 -> DONE, no char_valid.
//    MAX_CHARS!=0 && count==MAX_CHARS -> truncated<=1; -> DONE.
//    Otherwise char_valid=1, char_data=byte; hold until char_ready.
//    On handshake: addr_reg<=addr_reg+1; count<=count+1.
//      If addr_reg[1:0]==3 -> FETCH (next word), else stay in EMIT.
//  DONE: cpu_stall=0; done=1 for exactly one cycle; syscall_valid ignored; -> IDLE.
//    The CPU advances past the syscall on this edge.
//  cpu_stall=1 in FETCH and EMIT, and in IDLE on accept. busy=1 in FETCH, EMIT, DONE.
//  In any state other than IDLE, CPU mem_read/mem_write never reach memory; mem_write=0.
//  cpu_read_data = mem_read_data in all states (ignored by the stalled CPU).
//  Latency: accept edge -> FETCH edge -> first char_valid in the next cycle (2 cycles).
//  Word boundary: each 4 chars cost 1 extra FETCH cycle; an unaligned start begins mid-word.
//  Address wrap: 32'hFFFFFFFF+1 wraps to 0; no fault is raised.
//  rst_n low mid-string: immediate return to IDLE; char_valid drops asynchronously; no done.
//  char_ready with char_valid low: no effect.
// CONFIGURATION
//  PRINT_NEWLINE_EN defined: on the NUL or truncation exit from EMIT, first emit 8'h0A
//    via the normal handshake (NEWLINE sub-state, not counted against MAX_CHARS), then DONE.
//  PRINT_NEWLINE_EN undefined: EMIT goes straight to DONE; no extra character.
// TESTING
//  1 Mem @0x100 = 0x6C6C6548, @0x104 = 0x0000216F; code=4, arg=0x100, ready=1
//    -> chars 'H','e','l','l','o','!'; done pulses once; stall drops in DONE.
//  2 Same string, arg=0x102 -> "llo!" only; first FETCH address is 0x100.
//  3 char_ready held low 10 cycles on the first char -> char_valid/char_data stable 10 cycles,
//    no address advance.
//  4 MAX_CHARS=3 with "Hello" -> "Hel"; truncated=1; done pulses.
//  5 CPU store to 0x200 issued while in EMIT -> mem_write stays 0 and memory is unchanged;
//    code=1 -> no stall; rst_n low mid-EMIT -> IDLE next cycle, no done.
//  6 PRINT_NEWLINE_EN with string "A" -> 'A', 8'h0A, then done.

Source files
------------

// File: rtl/syscall_print_arbiter.sv
// syscall_print_arbiter
// This block shares the single data-memory port between the CPU load/store path and a
// print_string syscall engine. When the CPU raises syscall code PRINT_CODE, the block stalls
// the CPU. It then walks the NUL-terminated string at $a0 one word per fetch and hands out
// one byte per char_valid/char_ready handshake.
// Optional feature: define PRINT_NEWLINE_EN to append 8'h0A after each string, on both the
// NUL exit and the truncation exit.
module syscall_print_arbiter #(
  parameter int unsigned MAX_CHARS  = 256,   // 0 = unlimited
  parameter logic [31:0] PRINT_CODE = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  input  logic        syscall_valid,
  input  logic [31:0] syscall_code,
  input  logic [31:0] syscall_arg,
  output logic        cpu_stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        busy,
  output logic        done,
  output logic        truncated
);

`ifdef PRINT_NEWLINE_EN
  typedef enum logic [2:0] {IDLE, FETCH, EMIT, NEWLINE, DONE} state_t;
  localparam state_t EXIT_STATE = NEWLINE;
`else
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
  localparam state_t EXIT_STATE = DONE;
`endif

  state_t      state;
  logic [31:0] word_reg;
  logic [31:0] addr_reg;
  logic [31:0] count;

  logic        accept;
  logic [7:0]  cur_byte;
  logic        is_nul;
  logic        at_cap;

  assign accept   = (state == IDLE) && syscall_valid && (syscall_code == PRINT_CODE);
  assign cur_byte = word_reg[{addr_reg[1:0], 3'b000} +: 8];   // little-endian byte select
  assign is_nul   = (cur_byte == 8'h00);
  assign at_cap   = (MAX_CHARS != 0) && (count == 32'(MAX_CHARS));

  assign cpu_read_data = mem_read_data;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // Memory-port mux, stall and character outputs. These are combinational so that the stall
  // asserts in the accept cycle and char_valid drops as soon as reset asserts.
  // NOTE: every output gets a default first so that no path through the case infers a latch.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = {addr_reg[31:2], 2'b00};
    mem_write_data = cpu_write_data;
    char_valid     = 1'b0;
    char_data      = cur_byte;
    cpu_stall      = 1'b0;
    case (state)
      IDLE: begin
        mem_address = cpu_address;
        if (accept) begin
          cpu_stall = 1'b1;           // CPU access in the accept cycle is dropped
        end else begin
          mem_read  = cpu_mem_read;
          mem_write = cpu_mem_write;
        end
      end
      FETCH: begin
        mem_read  = 1'b1;
        cpu_stall = 1'b1;
      end
      EMIT: begin
        cpu_stall  = 1'b1;
        char_valid = !is_nul && !at_cap;
      end
`ifdef PRINT_NEWLINE_EN
      NEWLINE: begin
        cpu_stall  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h0A;
      end
`endif
      default: ;                      // DONE: CPU released, port idle
    endcase
  end

  // Syscall engine: accept, fetch a word, emit its bytes, then return to IDLE through DONE.
  // NOTE: sequential state uses non-blocking assignments so that every register samples
  // pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_reg  <= '0;
      addr_reg  <= '0;
      count     <= '0;
      truncated <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_reg  <= syscall_arg;
            count     <= '0;
            truncated <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          word_reg <= mem_read_data;
          state    <= EMIT;
        end
        EMIT: begin
          if (is_nul) begin
            state <= EXIT_STATE;
          end else if (at_cap) begin
            truncated <= 1'b1;
            state     <= EXIT_STATE;
          end else if (char_ready) begin
            addr_reg <= addr_reg + 32'd1;   // wraps past 32'hFFFFFFFF silently
            count    <= count + 32'd1;
            if (addr_reg[1:0] == 2'd3) state <= FETCH;
          end
        end
`ifdef PRINT_NEWLINE_EN
        NEWLINE: begin
          if (char_ready) state <= DONE;
        end
`endif
        default: state <= IDLE;             // DONE lasts one cycle
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_print_arbiter.sv
// Directed bench for syscall_print_arbiter. dut0 uses default parameters. dut1 has
// MAX_CHARS=3 and exercises truncation. A word memory (combinational read, negedge write)
// backs both instances.
module tb_syscall_print_arbiter;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
  logic [31:0] cpu_address = '0, cpu_write_data = '0;
  logic [31:0] cpu_read_data;
  logic        syscall_valid = 1'b0, syscall_valid1 = 1'b0;
  logic [31:0] syscall_code = '0, syscall_arg = '0;
  logic        cpu_stall, mem_read, mem_write, char_valid, busy, done, truncated;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;

  logic [31:0] cpu_read_data1, mem_address1, mem_write_data1, mem_read_data1;
  logic        cpu_stall1, mem_read1, mem_write1, char_valid1, busy1, done1, truncated1;
  logic [7:0]  char_data1;

  logic [31:0] mem [0:255];

  int   checks = 0;
  int   errors = 0;
  bq_t  chars, chars1, exp_q;
  logic [31:0] fetch_q[$];
  int   done_cnt = 0, done1_cnt = 0;

  always #5 clk = ~clk;

  assign mem_read_data  = mem[mem_address[9:2]];
  assign mem_read_data1 = mem[mem_address1[9:2]];

  always @(negedge clk) begin
    if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
  end

  // Inputs are stable from posedge+1 to the next posedge, so negedge sees the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid && char_ready)  chars.push_back(char_data);
      if (char_valid1 && char_ready) chars1.push_back(char_data1);
      if (busy && mem_read)          fetch_q.push_back(mem_address);
      if (done)  done_cnt++;
      if (done1) done1_cnt++;
    end
  end

  syscall_print_arbiter dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data),
    .syscall_valid(syscall_valid), .syscall_code(syscall_code), .syscall_arg(syscall_arg),
    .cpu_stall(cpu_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .busy(busy), .done(done), .truncated(truncated)
  );

  syscall_print_arbiter #(.MAX_CHARS(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_read(1'b0), .cpu_mem_write(1'b0),
    .cpu_address(32'h0), .cpu_write_data(32'h0),
    .cpu_read_data(cpu_read_data1),
    .syscall_valid(syscall_valid1), .syscall_code(syscall_code), .syscall_arg(syscall_arg),
    .cpu_stall(cpu_stall1), .mem_read(mem_read1), .mem_write(mem_write1),
    .mem_address(mem_address1), .mem_write_data(mem_write_data1), .mem_read_data(mem_read_data1),
    .char_valid(char_valid1), .char_data(char_data1), .char_ready(char_ready),
    .busy(busy1), .done(done1), .truncated(truncated1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_chars(input string tag, input bq_t got, input bq_t exp);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check($sformatf("%s_c%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
  endtask

  task automatic clear_logs;
    chars.delete();
    chars1.delete();
    fetch_q.delete();
    done_cnt  = 0;
    done1_cnt = 0;
  endtask

  // Accept cycle for dut0: the stall is immediate and the CPU read is blocked.
  task automatic accept0(input logic [31:0] arg, input string tag);
    tick;
    syscall_valid = 1'b1;
    syscall_code  = 32'd4;
    syscall_arg   = arg;
    cpu_mem_read  = 1'b1;
    #1;
    check({tag, "_accept_stall"}, {31'h0, cpu_stall}, 32'd1);
    check({tag, "_accept_rd_blocked"}, {31'h0, mem_read}, 32'd0);
    tick;
    syscall_valid = 1'b0;
    cpu_mem_read  = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick;
      n++;
    end
    check({tag, "_done_seen"}, {31'h0, done}, 32'd1);
    check({tag, "_stall_in_done"}, {31'h0, cpu_stall}, 32'd0);
    tick;
    check({tag, "_idle_after"}, {31'h0, busy}, 32'd0);
  endtask

  task automatic add_nl;
`ifdef PRINT_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h6C6C6548;   // "Hell" at 0x100
    mem[8'h41] = 32'h0000216F;   // "o!\0" at 0x104
    mem[8'h60] = 32'h00000041;   // "A\0" at 0x180
    mem[8'h80] = 32'h11112222;   // store target 0x200

    // Reset state
    #12;
    check("rst_stall", {31'h0, cpu_stall}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_valid", {31'h0, char_valid}, 32'd0);
    check("rst_trunc", {31'h0, truncated}, 32'd0);
    rst_n = 1'b1;
    clear_logs();

    // 1: aligned "Hello!"
    char_ready = 1'b1;
    accept0(32'h100, "t1");
    #1;
    check("t1_fetch_rd", {31'h0, mem_read}, 32'd1);
    check("t1_fetch_addr", mem_address, 32'h100);
    check("t1_fetch_valid", {31'h0, char_valid}, 32'd0);
    tick;
    check("t1_first_valid", {31'h0, char_valid}, 32'd1);
    check("t1_first_char", {24'h0, char_data}, 32'h48);
    wait_done0("t1");
    exp_q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
    add_nl();
    check_chars("t1_str", chars, exp_q);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_fetch_cnt", 32'(fetch_q.size()), 32'd2);
    if (fetch_q.size() == 2) check("t1_fetch2", fetch_q[1], 32'h104);
    check("t1_not_trunc", {31'h0, truncated}, 32'd0);

    // 2: unaligned start at 0x102
    clear_logs();
    accept0(32'h102, "t2");
    wait_done0("t2");
    exp_q = '{8'h6C, 8'h6C, 8'h6F, 8'h21};
    add_nl();
    check_chars("t2_str", chars, exp_q);
    if (fetch_q.size() > 0) check("t2_fetch0", fetch_q[0], 32'h100);
    else check("t2_fetch_cnt", 32'(fetch_q.size()), 32'd2);

    // 3: backpressure on the first character
    clear_logs();
    char_ready = 1'b0;
    accept0(32'h100, "t3");
    tick;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_hold_valid%0d", i), {31'h0, char_valid}, 32'd1);
      check($sformatf("t3_hold_char%0d", i), {24'h0, char_data}, 32'h48);
      tick;
    end
    check("t3_no_advance", 32'(chars.size()), 32'd0);
    char_ready = 1'b1;
    wait_done0("t3");
    exp_q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
    add_nl();
    check_chars("t3_str", chars, exp_q);

    // 4: MAX_CHARS=3 truncation on dut1
    clear_logs();
    tick;
    syscall_valid1 = 1'b1;
    syscall_code   = 32'd4;
    syscall_arg    = 32'h100;
    tick;
    syscall_valid1 = 1'b0;
    for (int n = 0; n < 200 && !done1; n++) tick;
    check("t4_done_seen", {31'h0, done1}, 32'd1);
    tick;
    tick;
    exp_q = '{8'h48, 8'h65, 8'h6C};
    add_nl();
    check_chars("t4_str", chars1, exp_q);
    check("t4_trunc_sticky", {31'h0, truncated1}, 32'd1);
    check("t4_done_cnt", 32'(done1_cnt), 32'd1);

    // 5: CPU store blocked mid-EMIT, reset mid-string, non-print syscall passes through
    clear_logs();
    char_ready = 1'b0;
    accept0(32'h100, "t5");
    tick;
    cpu_mem_write  = 1'b1;
    cpu_address    = 32'h200;
    cpu_write_data = 32'hDEADBEEF;
    #1;
    check("t5_wr_blocked", {31'h0, mem_write}, 32'd0);
    tick;
    tick;
    check("t5_mem_kept", mem[8'h80], 32'h11112222);
    cpu_mem_write = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'h0, char_valid}, 32'd0);
    check("t5_rst_busy", {31'h0, busy}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    check("t5_no_done", 32'(done_cnt), 32'd0);
    syscall_valid  = 1'b1;
    syscall_code   = 32'd1;
    cpu_mem_write  = 1'b1;
    #1;
    check("t5_code1_stall", {31'h0, cpu_stall}, 32'd0);
    check("t5_code1_wr", {31'h0, mem_write}, 32'd1);
    tick;
    syscall_valid = 1'b0;
    cpu_mem_write = 1'b0;
    check("t5_code1_idle", {31'h0, busy}, 32'd0);
    check("t5_mem_written", mem[8'h80], 32'hDEADBEEF);
    cpu_mem_read = 1'b1;
    #1;
    check("t5_rd_pass", cpu_read_data, 32'hDEADBEEF);
    cpu_mem_read = 1'b0;

    // 6: single-character string
    clear_logs();
    char_ready = 1'b1;
    accept0(32'h180, "t6");
    wait_done0("t6");
    exp_q = '{8'h41};
    add_nl();
    check_chars("t6_str", chars, exp_q);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
